dual_port_ram_stream_reader: RTL and testbench

//  Read-side engine for dual_port_ram: on a start command, streams LENGTH consecutive words
//  out of the RAM read port as a valid/ready stream, with a last marker and a done pulse.

---
 rtl/dual_port_ram_stream_reader.sv | 102 ++++++++++
 tb/tb_dual_port_ram_stream_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_stream_reader.sv
// dual_port_ram_stream_reader: streams consecutive RAM words out as valid/ready with last/done; optional DPRAM_STREAM_READER_WRAP_EN circular addressing
module dual_port_ram_stream_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef DPRAM_STREAM_READER_WRAP_EN
    input  logic [ADDR_WIDTH-1:0] wrap_base,
    input  logic [ADDR_WIDTH-1:0] wrap_limit,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;
    logic [LEN_WIDTH-1:0]  len_q, issued, left;
    logic [DATA_WIDTH-1:0] mem [4];
    logic [1:0]            wp, rp;
    logic [2:0]            cnt;
    logic [3:0]            occ;
    logic                  v1, v2, accept, issue, pop, last_pop;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    assign busy      = state != IDLE;
    assign out_valid = cnt != 3'd0;
    assign out_data  = mem[rp];
    assign out_last  = out_valid && left == LEN_WIDTH'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    // Next state, issue decision (occupancy counts FIFO plus both in-flight stages) and next address
    always_comb begin
        pop       = out_valid && out_ready;
        last_pop  = pop && left == LEN_WIDTH'(1);
        accept    = state == IDLE && start;
        occ       = {1'b0, cnt} + {3'b0, v1} + {3'b0, v2} - {3'b0, pop};
        issue     = state == RUN && issued < len_q && occ < 4'd4;
`ifdef DPRAM_STREAM_READER_WRAP_EN
        addr_nxt  = raddr == wrap_limit ? wrap_base : raddr + 1'b1;
`else
        addr_nxt  = raddr + 1'b1;
`endif
        state_nxt = state == IDLE ? (accept && length != '0 ? RUN : IDLE) :
                    state == RUN  ? (issued == len_q ? DRAIN : RUN) :
                                    (last_pop ? IDLE : DRAIN);
    end

    // Read issue, in-flight pipeline, FIFO pointers/count and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            raddr  <= '0;
            len_q  <= '0;
            issued <= '0;
            left   <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= (accept && length == '0) || (state == DRAIN && last_pop);
            if (accept && length != '0) begin
                raddr  <= start_addr;
                len_q  <= length;
                issued <= LEN_WIDTH'(1);
                left   <= length;
            end else begin
                if (issue) begin
                    raddr  <= addr_nxt;
                    issued <= issued + LEN_WIDTH'(1);
                end
                left <= left - LEN_WIDTH'(pop);
            end
            v1  <= (accept && length != '0) || issue;
            v2  <= v1;
            wp  <= wp + {1'b0, v2};
            rp  <= rp + {1'b0, pop};
            cnt <= cnt + {2'b0, v2} - {2'b0, pop};
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (v2) mem[wp] <= ram_dout;
    end
endmodule

// File: tb/tb_dual_port_ram_stream_reader.sv
// tb_dual_port_ram_stream_reader: vector table, random transfers and corner sequences against a queue-based model
module tb_dual_port_ram_stream_reader;
    localparam int AW = 12, DW = 32, LW = 13;
    logic clk = 0, reset = 1, start = 0, out_ready = 0;
    logic [AW-1:0] start_addr = 0, raddr, wrap_base = 0, wrap_limit = '1;
    logic [LW-1:0] length = 0;
    logic busy, done, out_valid, out_last;
    logic [DW-1:0] ram_dout, out_data;
    logic [DW-1:0] ram [4096];
    logic [DW-1:0] exp_q [$];
    int errors = 0, checks = 0;
    bit prev_last = 0, prev_hold = 0;
    logic [DW-1:0] hold_data;
    logic hold_last;

    always #5 clk = ~clk;

    dual_port_ram_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .length(length),
`ifdef DPRAM_STREAM_READER_WRAP_EN
        .wrap_base(wrap_base), .wrap_limit(wrap_limit),
`endif
        .busy(busy), .done(done), .raddr(raddr), .ram_dout(ram_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always @(posedge clk) ram_dout <= ram[raddr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
`ifdef DPRAM_STREAM_READER_WRAP_EN
        return a == wrap_limit ? wrap_base : a + 1'b1;
`else
        return a + 1'b1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_words(input logic [AW-1:0] sa, input int len);
        logic [AW-1:0] a = sa;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(ram[a]);
            a = next_addr(a);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            step();
            seen = done;
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_busy_in_done"}, busy, 0);
        chk({name, "_words_left"}, exp_q.size(), 0);
    endtask

    // Stream monitor: every handshake is matched against the model queue
    always @(negedge clk) begin
        if (reset) begin
            prev_last = 0;
            prev_hold = 0;
        end else begin
            if (prev_last) chk("done_after_last", done, 1);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_data);
                chk("hold_last", out_last, hold_last);
            end
            prev_last = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else begin
                    chk("data", out_data, exp_q[0]);
                    chk("last", out_last, exp_q.size() == 1);
                    prev_last = exp_q.size() == 1;
                    void'(exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end
    end

    typedef struct {
        logic [AW-1:0] sa;
        int            len;
        int            mode;
        bit            poke;
    } vec_t;
    vec_t vecs [10];

    task automatic transfer(input vec_t v);
        bit seen = 0;
        expect_words(v.sa, v.len);
        start = 1; start_addr = v.sa; length = LW'(v.len); out_ready = 1;
        step();
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("raddr_first", raddr, v.sa);
        for (int c = 0; c < 400 && !seen; c++) begin
            out_ready = v.mode == 0 ? 1'b1 : v.mode == 1 ? ~out_ready : 1'($urandom_range(0, 1));
            if (v.poke && c == 2) begin
                start = 1; start_addr = v.sa + 12'd7; length = 3;
            end else start = 0;
            step();
            seen = done;
        end
        start = 0; out_ready = 0;
        chk("xfer_done_seen", seen, 1);
        chk("xfer_busy_in_done", busy, 0);
        chk("xfer_words_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [AW-1:0] a0;
        bit bad;
        for (int k = 0; k < 4096; k++) ram[k] = DW'(k + 'h100);
        vecs[0] = '{12'h004, 8, 0, 0};
        vecs[1] = '{12'h004, 8, 1, 0};
        vecs[2] = '{12'h100, 1, 0, 0};
        vecs[3] = '{12'h200, 9, 1, 1};
        vecs[4] = '{12'hFFD, 6, 2, 0};
        for (int i = 5; i < 10; i++) vecs[i] = '{AW'($urandom), $urandom_range(1, 20), 2, i == 6};

        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_raddr", raddr, 0);
        reset = 0;

        // Latency and full-rate streaming
        expect_words(12'h004, 8);
        out_ready = 1; start = 1; start_addr = 12'h004; length = 8;
        step();
        start = 0;
        chk("t1_raddr", raddr, 12'h004);
        chk("t1_busy", busy, 1);
        chk("t1_valid_n1", out_valid, 0);
        step();
        chk("t1_valid_n2", out_valid, 0);
        step();
        chk("t1_valid_n3", out_valid, 1);
        chk("t1_first", out_data, 32'h104);
        bad = 0;
        for (int k = 4; k <= 10; k++) begin
            step();
            bad |= !out_valid;
        end
        chk("t1_no_bubble", bad, 0);
        step();
        chk("t1_done_n11", done, 1);
        chk("t1_busy_done", busy, 0);
        chk("t1_empty", exp_q.size(), 0);
        step();
        chk("t1_done_pulse", done, 0);

        // Address roll-over at top of memory
        expect_words(12'hFFE, 4);
        start = 1; start_addr = 12'hFFE; length = 4;
        step();
        start = 0;
        chk("roll_a0", raddr, 12'hFFE);
        step(); chk("roll_a1", raddr, 12'hFFF);
        step(); chk("roll_a2", raddr, 12'h000);
        step(); chk("roll_a3", raddr, 12'h001);
        wait_done("roll");
        step();

        // Zero-length command
        a0 = raddr;
        start = 1; start_addr = 12'h055; length = 0;
        step();
        start = 0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_raddr", raddr, a0);
        chk("zero_valid", out_valid, 0);
        step();
        chk("zero_done_pulse", done, 0);
        chk("zero_valid2", out_valid, 0);

        foreach (vecs[i]) transfer(vecs[i]);

        // Reset mid-transfer aborts silently
        expect_words(12'h020, 10);
        out_ready = 0; start = 1; start_addr = 12'h020; length = 10;
        step();
        start = 0;
        repeat (4) step();
        reset = 1;
        step();
        exp_q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_last", out_last, 0);
        chk("abort_raddr", raddr, 0);
        reset = 0; out_ready = 1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            bad |= done | out_valid;
        end
        chk("abort_quiet", bad, 0);
        transfer('{12'h030, 5, 1, 0});

`ifdef DPRAM_STREAM_READER_WRAP_EN
        wrap_base = 12'h010; wrap_limit = 12'h013;
        expect_words(12'h012, 5);
        out_ready = 1; start = 1; start_addr = 12'h012; length = 5;
        step();
        start = 0;
        chk("wrap_a0", raddr, 12'h012);
        step(); chk("wrap_a1", raddr, 12'h013);
        step(); chk("wrap_a2", raddr, 12'h010);
        step(); chk("wrap_a3", raddr, 12'h011);
        step(); chk("wrap_a4", raddr, 12'h012);
        wait_done("wrap");
        wrap_base = 0; wrap_limit = '1;
`endif

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
